// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: byte-wide instruction memory port, instruction hand-off to
// the ALU, and the call/ret redirect path.
interface inst_fetch_if;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [31:0] ope;
    logic [3:0]  num_of_ope;
    logic [31:0] eip_out;
    logic        illegal;
    logic        ope_valid;
    logic        ope_ready;
    logic        redirect_valid;
    logic [31:0] redirect_addr;

    modport master (
        output mem_addr, mem_rd, ope, num_of_ope, eip_out, illegal, ope_valid,
        input  mem_data, ope_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  mem_addr, mem_rd, ope, num_of_ope, eip_out, illegal, ope_valid,
        output mem_data, ope_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: reads one byte per REQ/CAP pair, sizes the
// instruction from its opcode, and holds the packed result until accepted.
module inst_fetch #(
    parameter logic [31:0] RESET_EIP = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {REQ, CAP, HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_fetch_ptr;
    logic [2:0]  r_cnt;
    logic [31:0] r_ope;
    logic [3:0]  r_num;
    logic [31:0] r_eip;
    logic        r_ill;
    logic        r_ope_valid;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;

    logic [3:0]  w_len;
    logic        w_ill;
    logic [3:0]  w_cur_len;
    logic        w_last;
    logic [31:0] w_ptr_inc;

    always_comb begin
        w_len = 4'd1;
        w_ill = 1'b0;
        case (bus.mem_data)
            8'h55, 8'h5d, 8'hc3, 8'hc9: w_len = 4'd1;
            8'h89, 8'h6a:               w_len = 4'd2;
            8'h8b, 8'h83:               w_len = 4'd3;
            8'hb8, 8'he8:               w_len = 4'd5;
            default:                    w_ill = 1'b1;
        endcase
    end

    // The length is only known from the opcode byte itself, so byte 0 uses the
    // live lookup and later bytes use the stored length.
    assign w_cur_len = (r_cnt == 3'd0) ? w_len : r_num;
    assign w_last    = ({1'b0, r_cnt} == (w_cur_len - 4'd1));
    assign w_ptr_inc = r_fetch_ptr + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= REQ;
            r_fetch_ptr <= RESET_EIP;
            r_cnt       <= 3'd0;
            r_ope       <= 32'd0;
            r_num       <= 4'd0;
            r_eip       <= RESET_EIP;
            r_ill       <= 1'b0;
            r_ope_valid <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= RESET_EIP;
        end else if (bus.redirect_valid) begin
            r_fetch_ptr <= bus.redirect_addr;
            r_cnt       <= 3'd0;
            r_ope_valid <= 1'b0;
            r_ope       <= 32'd0;
            r_state     <= REQ;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= bus.redirect_addr;
        end else begin
            case (r_state)
                REQ: begin
                    // Out of reset the strobe is low; the first edge raises it
                    // without consuming a read.
                    if (!r_mem_rd) begin
                        r_mem_rd <= 1'b1;
                    end else begin
                        r_mem_rd <= 1'b0;
                        r_state  <= CAP;
                        if (r_cnt == 3'd0)
                            r_eip <= r_fetch_ptr;
                    end
                end
                CAP: begin
                    r_fetch_ptr <= w_ptr_inc;
                    case (r_cnt)
                        3'd0: begin
                            r_ope <= {bus.mem_data, 24'd0};
                            r_num <= w_len;
                            r_ill <= w_ill;
                        end
                        3'd1:    r_ope[23:16] <= bus.mem_data;
                        3'd2:    r_ope[15:8]  <= bus.mem_data;
                        3'd3:    r_ope[7:0]   <= bus.mem_data;
                        default: ;
                    endcase
                    if (w_last) begin
                        r_cnt       <= 3'd0;
                        r_state     <= HOLD;
                        r_ope_valid <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 3'd1;
                        r_state    <= REQ;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_ptr_inc;
                    end
                end
                HOLD: begin
                    if (bus.ope_ready) begin
                        r_ope_valid <= 1'b0;
                        r_state     <= REQ;
                        r_mem_rd    <= 1'b1;
                        r_mem_addr  <= r_fetch_ptr;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rd     = r_mem_rd;
    assign bus.ope        = r_ope;
    assign bus.num_of_ope = r_num;
    assign bus.eip_out    = r_eip;
    assign bus.illegal    = r_ill;
    assign bus.ope_valid  = r_ope_valid;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_EIP, default 32'h00000000, which is the fetch address loaded on reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port mem_addr, output, 32 bits: byte address to instruction memory.
REQ-005 SHALL have port mem_rd, output, 1 bit: read strobe; mem_data is valid in the following cycle.
REQ-006 SHALL have port mem_data, input, 8 bits: read byte, one cycle after mem_rd.
REQ-007 SHALL have port ope, output, 32 bits: packed instruction to the ALU.
REQ-008 SHALL have port num_of_ope, output, 4 bits: instruction length in bytes.
REQ-009 SHALL have port eip_out, output, 32 bits: address of byte 0 of the held instruction.
REQ-010 SHALL have port illegal, output, 1 bit: the held opcode is not in the length table.
REQ-011 SHALL have port ope_valid, output, 1 bit: ope, num_of_ope, eip_out and illegal are valid.
REQ-012 SHALL have port ope_ready, input, 1 bit: the consumer accepts the held instruction.
REQ-013 SHALL have port redirect_valid, input, 1 bit, and port redirect_addr, input, 32 bits: load a new fetch address (call/ret target).

Function
REQ-014 SHALL implement FSM states REQ, CAP, HOLD.
- REQ: mem_rd=1, mem_addr=fetch_ptr.
- CAP: mem_rd=0; capture mem_data; fetch_ptr+1; byte count+1.
REQ-015 SHALL, in CAP with byte count 0, look up the length L from byte 0:
- 55, 5d, c3, c9 -> 1
- 89, 6a -> 2
- 8b, 83 -> 3
- b8, e8 -> 5
- any other opcode -> 1, with illegal=1
REQ-016 SHALL pack byte k (k=0..3) into ope[31-8k -: 8].
REQ-017 SHALL zero the ope bytes beyond L at the start of each instruction.
REQ-018 SHALL, when L=5, fetch byte 4, advance fetch_ptr past it, and discard its value.
REQ-019 SHALL, after the CAP of byte L-1, enter HOLD with ope_valid=1.
REQ-020 SHALL, in CAP states that are not the last byte, return to REQ.
REQ-021 SHALL give a latency of exactly 2L cycles from the first REQ cycle to ope_valid high, with no stalls.
REQ-022 SHALL, in HOLD, keep ope, num_of_ope, eip_out and illegal stable and mem_rd=0 until ope_ready=1.
REQ-023 SHALL, on a cycle with ope_valid=1 and ope_ready=1, drop ope_valid and go to REQ on the next edge.
REQ-024 SHALL set eip_out = fetch_ptr at the first REQ of each instruction.
REQ-025 SHALL honour ope_ready only in HOLD, and ignore it elsewhere.
REQ-026 SHALL give redirect_valid the highest priority in any state.
- On that edge: fetch_ptr<=redirect_addr, byte count<=0, ope_valid<=0, ope<=0, state<=REQ.
- The held or partial instruction is discarded.
- A mem_data returning in the next cycle is ignored.
REQ-027 SHALL apply the redirect when redirect_valid and ope_ready are high together in HOLD, and treat the handshake as not completed.
REQ-028 SHALL let fetch_ptr and the mem_addr increment wrap from 32'hFFFFFFFF to 32'h00000000 without any flag.
REQ-029 SHALL stay in HOLD indefinitely with ope_ready=0; no extra memory reads and no output change.

Reset
REQ-030 SHALL, while reset=1, force asynchronously:
- state=REQ, fetch_ptr=RESET_EIP, byte count=0
- ope=0, num_of_ope=0, eip_out=RESET_EIP
- illegal=0, ope_valid=0, mem_rd=0, mem_addr=RESET_EIP
REQ-031 SHALL, on reset asserted mid-instruction or in HOLD, discard all partial state.
REQ-032 SHALL, on reset release, assert mem_rd at RESET_EIP on the first clock.

Verification
REQ-033 SHALL cover: memory at 0 = 55, ope_ready=1 -> ope=55000000, num_of_ope=1, eip_out=0, ope_valid high at cycle 2 for 1 cycle; next REQ at addr 1.
REQ-034 SHALL cover: bytes 83 ec 08 at addr 4 -> ope=83ec0800, num_of_ope=3, eip_out=4; ope_valid at cycle 6 after the first REQ; next fetch at 7.
REQ-035 SHALL cover: bytes e8 ee ff ff ff at 16 -> ope=e8eeffff, num_of_ope=5, 5 reads at 16..20, next fetch at 21.
REQ-036 SHALL cover: 89 e5 held with ope_ready=0 for 10 cycles -> outputs stable and mem_rd=0 throughout; accepted on the ope_ready pulse.
REQ-037 SHALL cover: redirect_valid with redirect_addr=32'h40 during the CAP of byte 1 of b8 -> ope_valid stays 0; next mem_addr=40; the instruction at 40 is delivered correctly.
REQ-038 SHALL cover both of:
- opcode 0f -> illegal=1, num_of_ope=1, ope=0f000000.
- reset pulse in HOLD -> ope_valid=0 at once, then fetch restarts at RESET_EIP.
